// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS mode codes, lock FSM state encodings and popcount helper
//   PRBS_MODE_7 / PRBS_MODE_15 : values of the mode input
//   state_e                    : lock FSM states
//   popcount                   : number of set bits in a word of up to 64 bits
package prbs_pkg;
  localparam logic PRBS_MODE_7  = 1'b0;
  localparam logic PRBS_MODE_15 = 1'b1;
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + 7'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/prbs_predict.sv
// prbs_predict: predicts one word of a x^ORDER+x^(ORDER-1)+1 PRBS stream from the previous bits
//   seed_i : last ORDER received bits, seed_i[0] oldest
//   pred_o : predicted word, pred_o[0] oldest
module prbs_predict #(
  parameter int WORDWIDTH = 16,
  parameter int ORDER     = 7
) (
  input  logic [ORDER-1:0]     seed_i,
  output logic [WORDWIDTH-1:0] pred_o
);
  logic [ORDER-1:0] c;
  logic b;
  always_comb begin
    c = seed_i;
    b = 1'b0;
    pred_o = '0;
    for (int i = 0; i < WORDWIDTH; i++) begin
      b = c[1] ^ c[0];
      pred_o[i] = b;
      c = {b, c[ORDER-1:1]};
    end
  end
endmodule

// File: rtl/prbs_lock_checker.sv
// prbs_lock_checker: self-synchronising PRBS7/PRBS15 checker with lock FSM and saturating error counters
//   clk, rstn    : clock, asynchronous active-low reset
//   din          : received word, din[0] oldest; dinValid qualifies it
//   mode         : 0 = PRBS7, 1 = PRBS15
//   clrCnt       : synchronous clear of both error counters
//   error        : registered word-mismatch flag
//   errBits      : registered count of mismatching bits
//   locked       : lock FSM is in LOCKED
//   errWordCnt   : saturating count of bad words seen while locked
//   errBitCnt    : saturating count of bad bits seen while locked
module prbs_lock_checker
  import prbs_pkg::*;
#(
  parameter int WORDWIDTH     = 16,
  parameter int LOCK_THRESH   = 8,
  parameter int UNLOCK_THRESH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [WORDWIDTH-1:0]               din,
  input  logic                               dinValid,
  input  logic                               mode,
  input  logic                               clrCnt,
  output logic                               error,
  output logic [$clog2(WORDWIDTH+1)-1:0]     errBits,
  output logic                               locked,
  output logic [CNT_WIDTH-1:0]               errWordCnt,
  output logic [CNT_WIDTH-1:0]               errBitCnt
);
  localparam int EBW = $clog2(WORDWIDTH + 1);
  localparam int CW1 = CNT_WIDTH + 1;
  state_e state_q, state_d;
  logic [7:0] good_q, good_d, bad_q, bad_d;
  logic [14:0] seed_q, seed_d;
  logic seeded_q, seeded_d, mode_q, error_q, error_d;
  logic [EBW-1:0] bits_q, bits_d, nbits;
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d, bcnt_q, bcnt_d;
  logic [CNT_WIDTH:0] wsum, bsum;
  logic [WORDWIDTH-1:0] p7, p15, mism;
  logic mode_chg, eval, bad, inc;
  // The PRBS7 chain is the newest 7 bits of the previous word.
  prbs_predict #(.WORDWIDTH(WORDWIDTH), .ORDER(7)) u_p7 (
    .seed_i(seed_q[14:8]),
    .pred_o(p7)
  );
  prbs_predict #(.WORDWIDTH(WORDWIDTH), .ORDER(15)) u_p15 (
    .seed_i(seed_q),
    .pred_o(p15)
  );
  always_comb begin
    mode_chg = mode != mode_q;
    mism = ((mode == PRBS_MODE_15) ? p15 : p7) ^ din;
    nbits = EBW'(popcount(64'(mism)));
    bad = |mism;
    // The first valid word after reset or a mode change only loads the seed.
    eval = dinValid && seeded_q && !mode_chg;
    state_d = state_q;
    good_d = good_q;
    bad_d = bad_q;
    seed_d = seed_q;
    seeded_d = seeded_q;
    error_d = error_q;
    bits_d = bits_q;
    inc = 1'b0;
    if (mode_chg) begin
      state_d = ST_UNLOCKED;
      good_d = '0;
      bad_d = '0;
      seeded_d = 1'b0;
    end
    if (dinValid) begin
      seed_d = din[WORDWIDTH-1 -: 15];
      seeded_d = 1'b1;
      error_d = eval && bad;
      bits_d = eval ? nbits : '0;
    end
    if (eval) begin
      case (state_q)
        ST_UNLOCKED: begin
          state_d = bad ? ST_UNLOCKED : ST_LOCKING;
          good_d = '0;
        end
        ST_LOCKING: begin
          state_d = bad ? ST_UNLOCKED : (good_q == 8'(LOCK_THRESH - 1)) ? ST_LOCKED : ST_LOCKING;
          good_d = (bad || good_q == 8'(LOCK_THRESH - 1)) ? '0 : good_q + 8'd1;
        end
        ST_LOCKED: begin
          inc = bad;
          state_d = (bad && bad_q == 8'(UNLOCK_THRESH - 1)) ? ST_UNLOCKED : ST_LOCKED;
          bad_d = (!bad || bad_q == 8'(UNLOCK_THRESH - 1)) ? '0 : bad_q + 8'd1;
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
    wsum = {1'b0, wcnt_q} + CW1'(1);
    bsum = {1'b0, bcnt_q} + CW1'(nbits);
    wcnt_d = clrCnt ? '0 : !inc ? wcnt_q : wsum[CNT_WIDTH] ? '1 : wsum[CNT_WIDTH-1:0];
    bcnt_d = clrCnt ? '0 : !inc ? bcnt_q : bsum[CNT_WIDTH] ? '1 : bsum[CNT_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_UNLOCKED;
      good_q <= '0;
      bad_q <= '0;
      seed_q <= '0;
      seeded_q <= 1'b0;
      mode_q <= PRBS_MODE_7;
      error_q <= 1'b0;
      bits_q <= '0;
      wcnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      state_q <= state_d;
      good_q <= good_d;
      bad_q <= bad_d;
      seed_q <= seed_d;
      seeded_q <= seeded_d;
      mode_q <= mode;
      error_q <= error_d;
      bits_q <= bits_d;
      wcnt_q <= wcnt_d;
      bcnt_q <= bcnt_d;
    end
  end
  assign error = error_q;
  assign errBits = bits_q;
  assign locked = state_q == ST_LOCKED;
  assign errWordCnt = wcnt_q;
  assign errBitCnt = bcnt_q;
endmodule
